// File: rtl/dmem_bus_ctrl_pkg.sv
// Shared definitions for the data-memory bus controller: load/store FUN3 codes,
// controller state encodings and default timeout.
package dmem_bus_ctrl_pkg;

    localparam logic [2:0] FUN3_LB  = 3'b000;
    localparam logic [2:0] FUN3_LH  = 3'b001;
    localparam logic [2:0] FUN3_LW  = 3'b010;
    localparam logic [2:0] FUN3_LBU = 3'b100;
    localparam logic [2:0] FUN3_LHU = 3'b101;
    localparam logic [2:0] FUN3_SB  = 3'b000;
    localparam logic [2:0] FUN3_SH  = 3'b001;
    localparam logic [2:0] FUN3_SW  = 3'b010;

    typedef enum logic [1:0] {
        DBC_IDLE = 2'b00,
        DBC_BUSY = 2'b01,
        DBC_DONE = 2'b10
    } dbc_state_e;

    localparam int DBC_TIMEOUT_DEF = 16;

    // A store with no byte enables touches nothing and never reaches the bus.
    function automatic logic is_null_store(input logic we, input logic [3:0] wstrb);
        return we && (wstrb == 4'b0000);
    endfunction

endpackage

// File: rtl/dmem_bus_ctrl_wait_counter.sv
// Bounded wait counter: counts stalled bus cycles and flags the last allowed one.
module dbc_wait_counter #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CNT_W-1:0] count_r;

    assign tc = (count_r == CNT_W'(TIMEOUT - 1));

    // Count up while enabled, saturating at the terminal value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            count_r <= {CNT_W{1'b0}};
        end else if (en && !tc) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/dmem_bus_ctrl.sv
// CPU data port to req/ack memory bus bridge: registers the access, stalls the
// core until ack, latches read data, and aborts with cpu_err on timeout.
module dmem_bus_ctrl
    import dmem_bus_ctrl_pkg::*;
#(
    parameter int TIMEOUT = DBC_TIMEOUT_DEF,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [3:0]  cpu_wstrb,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        cpu_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    dbc_state_e  state_r;
    dbc_state_e  state_nx_s;
    logic        accept_s;
    logic        null_store_s;
    logic        tc_s;
    logic        cnt_en_s;
    logic        bus_req_r;
    logic        bus_we_r;
    logic [31:0] bus_addr_r;
    logic [3:0]  bus_wstrb_r;
    logic [31:0] bus_wdata_r;
    logic [31:0] cpu_rdata_r;
    logic        cpu_err_r;
    logic [1:0]  addr_lsb_unused_s;

    assign addr_lsb_unused_s = cpu_addr[1:0];
    assign null_store_s      = is_null_store(cpu_we, cpu_wstrb);
    assign cnt_en_s          = (state_r == DBC_BUSY) && !bus_ack;

    dbc_wait_counter #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_wait_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept_s),
        .en    (cnt_en_s),
        .tc    (tc_s)
    );

    // Next-state decode; requests are only accepted from IDLE.
    always_comb begin
        state_nx_s = state_r;
        accept_s   = 1'b0;
        case (state_r)
            DBC_IDLE: begin
                if (cpu_req && !null_store_s) begin
                    accept_s   = 1'b1;
                    state_nx_s = DBC_BUSY;
                end else begin
                    state_nx_s = DBC_IDLE;
                end
            end
            DBC_BUSY: begin
                if (bus_ack || tc_s) begin
                    state_nx_s = DBC_DONE;
                end else begin
                    state_nx_s = DBC_BUSY;
                end
            end
            DBC_DONE: state_nx_s = DBC_IDLE;
            default:  state_nx_s = DBC_IDLE;
        endcase
    end

    // State, bus fields and CPU-side result registers; ack takes priority over timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= DBC_IDLE;
            bus_req_r   <= 1'b0;
            bus_we_r    <= 1'b0;
            bus_addr_r  <= 32'h0000_0000;
            bus_wstrb_r <= 4'b0000;
            bus_wdata_r <= 32'h0000_0000;
            cpu_rdata_r <= 32'h0000_0000;
            cpu_err_r   <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            cpu_err_r <= 1'b0;
            case (state_r)
                DBC_IDLE: begin
                    if (accept_s) begin
                        bus_req_r   <= 1'b1;
                        bus_we_r    <= cpu_we;
                        bus_addr_r  <= {cpu_addr[31:2], 2'b00};
                        bus_wstrb_r <= cpu_we ? cpu_wstrb : 4'b0000;
                        bus_wdata_r <= cpu_wdata;
                    end
                end
                DBC_BUSY: begin
                    if (bus_ack) begin
                        bus_req_r <= 1'b0;
                        if (!bus_we_r) begin
                            cpu_rdata_r <= bus_rdata;
                        end
                    end else if (tc_s) begin
                        bus_req_r   <= 1'b0;
                        cpu_rdata_r <= 32'h0000_0000;
                        cpu_err_r   <= 1'b1;
                    end
                end
                default: bus_req_r <= 1'b0;
            endcase
        end
    end

    assign cpu_stall = cpu_req && (state_r != DBC_DONE)
                       && !((state_r == DBC_IDLE) && null_store_s);
    assign cpu_rdata = cpu_rdata_r;
    assign cpu_err   = cpu_err_r;
    assign bus_req   = bus_req_r;
    assign bus_we    = bus_we_r;
    assign bus_addr  = bus_addr_r;
    assign bus_wstrb = bus_wstrb_r;
    assign bus_wdata = bus_wdata_r;

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Self-checking bench for dmem_bus_ctrl: directed scenarios plus randomized
// accesses checked against a per-transaction timing/result model.
module tb_dmem_bus_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [3:0]  cpu_wstrb;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        cpu_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_rdata = 32'h0;

    dmem_bus_ctrl #(.TIMEOUT(TO), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wstrb (cpu_wstrb),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .cpu_err   (cpu_err),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wstrb (bus_wstrb),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // One complete access: memory acks after 'delay' wait cycles (never if delay >= TO).
    task automatic run_access(input logic we, input logic [31:0] addr, input logic [3:0] strb,
                              input logic [31:0] wd, input int delay, input logic [31:0] rd,
                              input string tag);
        logic        tmo;
        int          busy_n;
        int          stall_n;
        logic [31:0] exp_addr;
        logic [3:0]  exp_strb;
        tmo      = (delay >= TO);
        busy_n   = tmo ? TO : delay + 1;
        exp_addr = {addr[31:2], 2'b00};
        exp_strb = we ? strb : 4'b0000;
        stall_n  = 0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wstrb = strb; cpu_wdata = wd;
        bus_ack = 1'b0;
        #1;
        checks++;
        if (bus_req !== 1'b0) begin
            errors++; $display("FAIL %s req_idle: got %b expected 0", tag, bus_req);
        end
        if (cpu_stall === 1'b1) stall_n++;
        for (int k = 0; k < busy_n; k++) begin
            @(negedge clk);
            bus_ack   = (k == delay);
            bus_rdata = (k == delay) ? rd : $urandom;
            #1;
            checks++;
            if ({bus_req, bus_we, bus_addr, bus_wstrb} !== {1'b1, we, exp_addr, exp_strb}) begin
                errors++;
                $display("FAIL %s bus_fields cyc%0d: got req=%b we=%b addr=%h strb=%b expected req=1 we=%b addr=%h strb=%b",
                         tag, k, bus_req, bus_we, bus_addr, bus_wstrb, we, exp_addr, exp_strb);
            end
            if (we) begin
                checks++;
                if (bus_wdata !== wd) begin
                    errors++; $display("FAIL %s wdata: got %h expected %h", tag, bus_wdata, wd);
                end
            end
            if (cpu_stall === 1'b1) stall_n++;
        end
        if (tmo) exp_rdata = 32'h0;
        else if (!we) exp_rdata = rd;
        @(negedge clk);
        bus_ack = 1'b0;
        #1;
        checks++;
        if (bus_req !== 1'b0) begin
            errors++; $display("FAIL %s req_done: got %b expected 0", tag, bus_req);
        end
        checks++;
        if (cpu_stall !== 1'b0) begin
            errors++; $display("FAIL %s stall_done: got %b expected 0", tag, cpu_stall);
        end
        checks++;
        if (cpu_err !== tmo) begin
            errors++; $display("FAIL %s err_done: got %b expected %b", tag, cpu_err, tmo);
        end
        checks++;
        if (cpu_rdata !== exp_rdata) begin
            errors++; $display("FAIL %s rdata: got %h expected %h", tag, cpu_rdata, exp_rdata);
        end
        checks++;
        if (stall_n != busy_n + 1) begin
            errors++; $display("FAIL %s stall_cycles: got %0d expected %0d", tag, stall_n, busy_n + 1);
        end
    endtask

    // Idle cycles with random spurious acks, which must be ignored.
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cpu_req   = 1'b0;
            bus_ack   = 1'($urandom_range(0, 1));
            bus_rdata = $urandom;
            #1;
            checks++;
            if ({bus_req, cpu_err, cpu_stall} !== 3'b000 || cpu_rdata !== exp_rdata) begin
                errors++;
                $display("FAIL idle: got req=%b err=%b stall=%b rdata=%h expected 0 0 0 %h",
                         bus_req, cpu_err, cpu_stall, cpu_rdata, exp_rdata);
            end
        end
        @(negedge clk);
        bus_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wstrb = 4'b0;
        cpu_wdata = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
        #1;
        checks++;
        if ({bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata, cpu_rdata, cpu_err, cpu_stall} !== 104'h0) begin
            errors++; $display("FAIL reset_outputs: got nonzero outputs, expected all 0");
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        exp_rdata = 32'h0;
    endtask

    task automatic test_load_basic();
        run_access(1'b0, 32'h1000_0006, 4'b1111, 32'h0, 0, 32'hDEAD_BEEF, "load_basic");
        idle_cycles(1);
    endtask

    task automatic test_store_wait();
        run_access(1'b1, 32'h2000_0010, 4'b0100, 32'h5A5A_5A5A, 3, 32'h1234_5678, "store_wait");
        idle_cycles(1);
    endtask

    task automatic test_timeout();
        run_access(1'b0, 32'h3000_0000, 4'b0000, 32'h0, TO + 3, 32'h0, "timeout");
        idle_cycles(1);
    endtask

    task automatic test_ack_at_limit();
        run_access(1'b0, 32'h3000_0008, 4'b0000, 32'h0, TO - 1, 32'hCAFE_F00D, "ack_at_limit");
        idle_cycles(1);
    endtask

    task automatic test_null_store();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cpu_req = 1'b1; cpu_we = 1'b1; cpu_wstrb = 4'b0000; cpu_addr = $urandom; bus_ack = 1'b0;
            #1;
            checks++;
            if (bus_req !== 1'b0 || cpu_stall !== 1'b0) begin
                errors++; $display("FAIL null_store: got req=%b stall=%b expected 0 0", bus_req, cpu_stall);
            end
        end
        idle_cycles(1);
    endtask

    task automatic test_back_to_back();
        run_access(1'b0, 32'h4000_0004, 4'b0000, 32'h0, 0, 32'h1111_2222, "b2b_first");
        run_access(1'b0, 32'h4000_0008, 4'b0000, 32'h0, 1, 32'h3333_4444, "b2b_second");
        idle_cycles(1);
    endtask

    task automatic test_flush();
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h5000_0000; cpu_wstrb = 4'b0011;
        cpu_wdata = 32'hA5A5_0000; bus_ack = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            cpu_req = 1'b0; bus_ack = (k == 1);
            #1;
            checks++;
            if (bus_req !== 1'b1 || cpu_stall !== 1'b0) begin
                errors++; $display("FAIL flush_busy: got req=%b stall=%b expected 1 0", bus_req, cpu_stall);
            end
        end
        @(negedge clk);
        bus_ack = 1'b0;
        #1;
        checks++;
        if (bus_req !== 1'b0 || cpu_err !== 1'b0) begin
            errors++; $display("FAIL flush_done: got req=%b err=%b expected 0 0", bus_req, cpu_err);
        end
        idle_cycles(1);
    endtask

    task automatic test_reset_mid_busy();
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h6000_0000; bus_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0; cpu_req = 1'b0;
        #1;
        checks++;
        if ({bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata, cpu_rdata, cpu_err, cpu_stall} !== 104'h0) begin
            errors++; $display("FAIL reset_mid_busy: got req=%b rdata=%h expected all 0", bus_req, cpu_rdata);
        end
        exp_rdata = 32'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus_ack = 1'b1; bus_rdata = 32'hBAD0_BAD0;
        #1;
        checks++;
        if (bus_req !== 1'b0 || cpu_rdata !== 32'h0) begin
            errors++; $display("FAIL late_ack: got req=%b rdata=%h expected 0 0", bus_req, cpu_rdata);
        end
        idle_cycles(2);
        run_access(1'b0, 32'h6000_0004, 4'b0000, 32'h0, 0, 32'h7777_8888, "after_reset");
        idle_cycles(1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            logic        we;
            logic [3:0]  strb;
            we   = 1'($urandom_range(0, 1));
            strb = we ? 4'($urandom_range(1, 15)) : 4'($urandom_range(0, 15));
            run_access(we, $urandom, strb, $urandom, $urandom_range(0, TO + 1), $urandom, "random");
            if ($urandom_range(0, 2) != 0) idle_cycles($urandom_range(1, 2));
        end
        idle_cycles(1);
    endtask

    initial begin
        test_reset();
        test_load_basic();
        test_store_wait();
        test_timeout();
        test_null_store();
        test_ack_at_limit();
        test_back_to_back();
        test_flush();
        test_reset_mid_busy();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_bus_ctrl.md
Name: dmem_bus_ctrl

Overview:
- Sits directly downstream of the load/store byte-lane handler, between the CPU data port and the external data-memory bus.
- Turns the single-cycle CPU access into a registered req/ack bus transaction, stalls the CPU until it completes, and holds read data stable for the handler's extraction logic.
- Includes a bounded-wait timeout that reports a bus error instead of hanging the core.

Parameters:
- TIMEOUT, 16: maximum cycles bus_req may stay high without bus_ack before the access is aborted (range 1..255).
- CNT_W, 8: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cpu_req  in  1  load or store present this cycle.
- cpu_we  in  1  1 = store, 0 = load (MemRW).
- cpu_addr  in  32  byte address from the ALU.
- cpu_wstrb  in  4  byte write enables from the handler.
- cpu_wdata  in  32  lane-replicated store data from the handler.
- cpu_rdata  out  32  latched memory word, fed to the handler's data-in.
- cpu_stall  out  1  freezes PC and pipeline while high.
- cpu_err  out  1  one-cycle pulse: access aborted by timeout.
- bus_req  out  1  transaction request.
- bus_we  out  1  transaction is a write.
- bus_addr  out  32  word-aligned address, {cpu_addr[31:2],2'b00}.
- bus_wstrb  out  4  byte enables (0000 on reads).
- bus_wdata  out  32  write data.
- bus_ack  in  1  one-cycle completion strobe from memory.
- bus_rdata  in  32  read word, valid in the bus_ack cycle.

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE.
  - bus_req, bus_we, bus_wstrb, bus_addr, bus_wdata, cpu_rdata, cpu_err and the wait counter are all 0.
  - Outputs drop immediately, mid-transaction included. No transaction resumes after reset.
- States: IDLE, BUSY, DONE (encodings in shared header).
- IDLE:
  - cpu_req=1 with (cpu_we=0 or cpu_wstrb!=0): register bus_addr, bus_we, bus_wstrb, bus_wdata; set bus_req=1; clear counter; go to BUSY.
  - cpu_req=1, cpu_we=1, cpu_wstrb=0000: null store. No bus transaction, no stall, stay IDLE.
- BUSY:
  - bus_req held high; all bus_* fields held stable until the ack edge.
  - Counter increments each cycle without ack.
  - bus_ack=1: capture bus_rdata into cpu_rdata (reads only; writes leave cpu_rdata unchanged), bus_req=0, go to DONE.
  - Counter reaches TIMEOUT-1 with no ack: bus_req=0, cpu_rdata=0, cpu_err pulses 1 cycle in DONE, go to DONE.
  - Ack and timeout in the same cycle: ack wins, no error.
- DONE: always returns to IDLE on the next edge. A new cpu_req is accepted only from IDLE.
- cpu_stall (combinational) = cpu_req & (state!=DONE) & ~(state==IDLE & null store).
- Latency: request seen in IDLE at cycle t; bus_req high t+1; earliest ack t+1; DONE at t+2 with stall low. Minimum access is 3 cycles, 2 of them stalled.
- bus_ack while in IDLE or DONE: spurious, ignored, no state change.
- cpu_req dropping during BUSY (flush): the transaction still completes or times out, and its result is discarded. cpu_stall follows cpu_req.
- cpu_rdata holds its value between captures.

Decomposition:
- Shared header gets the state encodings (DBC_IDLE/DBC_BUSY/DBC_DONE, 2-bit) and the default TIMEOUT constant, next to the existing load/store FUN3 macros.
- One sub-module: dbc_wait_counter (clear, enable, terminal-count flag, parameter TIMEOUT). Everything else stays in one always block plus the output assigns.

Test Plan:
- Load 0x1000_0006, ack on 1st BUSY cycle with bus_rdata=0xDEADBEEF -> bus_addr=0x1000_0004, bus_wstrb=0000, stall high 2 cycles, cpu_rdata=0xDEADBEEF in DONE.
- Store wstrb=0100, wdata=0x5A5A5A5A, ack after 3 wait cycles -> bus_* stable for 4 cycles, bus_we=1, stall 5 cycles, cpu_rdata unchanged.
- Load, no ack, TIMEOUT=4 -> bus_req drops after 4 cycles, cpu_err single pulse, cpu_rdata=0, stall released.
- Null store (cpu_we=1, wstrb=0000) -> bus_req never rises, cpu_stall stays 0.
- rst_n low mid-BUSY, then ack arrives after release -> all outputs 0 during reset, post-reset ack ignored, state IDLE.
- Ack on the TIMEOUT-1 cycle -> no cpu_err, data captured. Back-to-back loads -> second bus_req rises 1 cycle after DONE.
